// File: rtl/mux_4_arbiter.sv
// Round-robin 4:1 mux arbiter with bounded bursts; the owner holds the grant until it drops req or hits MAX_BURST.
// Latency: gnt/sel registered, one cycle after req is sampled; handoff on release has no idle bubble.
// Backpressure: none latched; requesters hold req until granted, non-owner requests wait for release.
module mux_4_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       last
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [2:0] MAX_CNT = 3'(MAX_BURST);

  state_t     state, state_n;
  logic [1:0] owner, owner_n;
  logic [1:0] ptr, ptr_n;
  logic [2:0] cnt, cnt_n;
  logic [3:0] gnt_n;
  logic [1:0] sel_n;

  logic [1:0] arb_start;
  logic [1:0] arb_idx;
  logic [1:0] winner;
  logic       found;

  // On release the search starts just past the owner, so ptr_n never has to feed back combinationally.
  assign arb_start = (state == GRANT) ? owner + 2'd1 : ptr;

  always_comb begin
    winner  = arb_start;
    arb_idx = arb_start;
    found   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      arb_idx = arb_start + 2'(k);
      if (!found && req[arb_idx]) begin
        winner = arb_idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    owner_n = owner;
    ptr_n   = ptr;
    cnt_n   = cnt;
    gnt_n   = gnt;
    sel_n   = sel;
    case (state)
      IDLE: begin
        gnt_n = 4'b0000;
        if (|req) begin
          state_n = GRANT;
          owner_n = winner;
          gnt_n   = 4'b0001 << winner;
          sel_n   = winner;
          cnt_n   = 3'd1;
        end
      end
      GRANT: begin
        if (req[owner] && (cnt < MAX_CNT)) begin
          cnt_n = cnt + 3'd1;
        end else begin
          ptr_n = owner + 2'd1;
          if (|req) begin
            owner_n = winner;
            gnt_n   = 4'b0001 << winner;
            sel_n   = winner;
            cnt_n   = 3'd1;
          end else begin
            state_n = IDLE;
            gnt_n   = 4'b0000;
            cnt_n   = 3'd0;
          end
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      owner <= 2'd0;
      ptr   <= 2'd0;
      cnt   <= 3'd0;
      gnt   <= 4'b0000;
      sel   <= 2'd0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
      gnt   <= gnt_n;
      sel   <= sel_n;
    end
  end

  assign busy = (state == GRANT);
  assign last = busy && (cnt == MAX_CNT);

endmodule

// File: tb/tb_mux_4_arbiter.sv
// Directed-vector bench for mux_4_arbiter: default MAX_BURST=4 instance plus a MAX_BURST=1 instance.
module tb_mux_4_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] req1;
  logic [3:0] gnt,  gnt1;
  logic [1:0] sel,  sel1;
  logic       busy, busy1;
  logic       last, last1;

  int checks = 0;
  int errors = 0;

  mux_4_arbiter #(.MAX_BURST(4)) u_dut (
    .clk(clk), .reset(reset), .req(req),
    .gnt(gnt), .sel(sel), .busy(busy), .last(last)
  );

  mux_4_arbiter #(.MAX_BURST(1)) u_dut1 (
    .clk(clk), .reset(reset), .req(req1),
    .gnt(gnt1), .sel(sel1), .busy(busy1), .last(last1)
  );

  always #5 clk = ~clk;

  // Observed word layout: {busy, last, sel[1:0], gnt[3:0]}
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got busy/last/sel/gnt=%b_%b_%b_%b expected %b_%b_%b_%b",
               tag, got[7], got[6], got[5:4], got[3:0], exp[7], exp[6], exp[5:4], exp[3:0]);
    end
  endtask

  function automatic logic [7:0] exp_word(input logic b, input logic l, input logic [1:0] s);
    logic [3:0] g;
    g = b ? (4'b0001 << s) : 4'b0000;
    return {b, l, s, g};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 4'b0000;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req   = 4'b0000;
    req1  = 4'b0000;
    step();
    step();
    check("reset_state", {busy, last, sel, gnt}, 8'b0000_0000);
    check("reset_state_mb1", {busy1, last1, sel1, gnt1}, 8'b0000_0000);
    reset = 1'b0;
    step();
    check("idle_no_req", {busy, last, sel, gnt}, 8'b0000_0000);

    // Single requester: 4-cycle burst then immediate re-grant
    req = 4'b0001;
    for (int c = 0; c < 6; c++) begin
      step();
      check($sformatf("single_c%0d", c), {busy, last, sel, gnt},
            exp_word(1'b1, (c % 4) == 3, 2'd0));
    end

    // Full contention from ptr=0
    do_reset();
    req = 4'b1111;
    for (int c = 0; c < 17; c++) begin
      step();
      check($sformatf("contend_c%0d", c), {busy, last, sel, gnt},
            exp_word(1'b1, (c % 4) == 3, 2'((c / 4) % 4)));
    end

    // Early drop: owner 0 releases after two cycles, 1 takes over with no bubble
    do_reset();
    req = 4'b0011;
    step();
    check("drop_c0", {busy, last, sel, gnt}, 8'b1000_0001);
    step();
    check("drop_c1", {busy, last, sel, gnt}, 8'b1000_0001);
    req = 4'b0010;
    step();
    check("drop_handoff", {busy, last, sel, gnt}, 8'b1001_0010);

    // Idle return: sel holds the last owner
    do_reset();
    req = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("idle_ret_c%0d", c), {busy, last, sel, gnt}, 8'b1010_0100);
    end
    req = 4'b0000;
    step();
    check("idle_ret_release", {busy, last, sel, gnt}, 8'b0010_0000);
    step();
    check("idle_ret_hold", {busy, last, sel, gnt}, 8'b0010_0000);

    // Reset mid-burst, then ptr restarts at 0
    req = 4'b0100;
    step();
    check("mid_grant", {busy, last, sel, gnt}, 8'b1010_0100);
    reset = 1'b1;
    step();
    check("mid_reset", {busy, last, sel, gnt}, 8'b0000_0000);
    reset = 1'b0;
    req = 4'b1010;
    step();
    check("post_reset_ptr0", {busy, last, sel, gnt}, 8'b1001_0010);

    // MAX_BURST=1: alternate 0 and 2, last always high
    do_reset();
    req1 = 4'b0101;
    for (int c = 0; c < 6; c++) begin
      step();
      check($sformatf("mb1_c%0d", c), {busy1, last1, sel1, gnt1},
            exp_word(1'b1, 1'b1, (c % 2 == 0) ? 2'd0 : 2'd2));
    end
    req1 = 4'b0000;
    step();
    check("mb1_idle", {busy1, last1, sel1, gnt1}, 8'b0010_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
